// File: rtl/cpu_mem_responder.sv
// CPU memory port target: on-chip RAM plus I/O page (GPIO, TX FIFO, status, cycle counter).
// Reads return one cycle after the strobe edge; writes land at the strobe edge; never stalls the core.
module cpu_mem_responder #(
  parameter int RAM_AWIDTH = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_raddr_i,
  input  logic        mem_rd_i,
  output logic [15:0] mem_rdata_o,
  input  logic [15:0] mem_waddr_i,
  input  logic [15:0] mem_wdata_i,
  input  logic        mem_wr_i,
  output logic [15:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [15:0] gpio_o
);

  localparam int          RAM_WORDS = 1 << RAM_AWIDTH;
  localparam logic [16:0] RAM_LIMIT = 17'(RAM_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [15:0] ADDR_GPIO   = 16'hFF00;
  localparam logic [15:0] ADDR_TX     = 16'hFF01;
  localparam logic [15:0] ADDR_STATUS = 16'hFF02;
  localparam logic [15:0] ADDR_CYCLE  = 16'hFF03;

  logic [15:0] ram_q [RAM_WORDS];
  logic [15:0] fifo_mem_q [FIFO_DEPTH];

  logic [15:0]   mem_rdata_q, mem_rdata_d;
  logic [15:0]   gpio_q, gpio_d;
  logic [15:0]   cycle_q, cycle_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic        wr_ram, rd_ram;
  logic        push, pop, push_ok;
  logic        fifo_full, fifo_empty;
  logic [15:0] rd_sel;

  assign rd_ram     = ({1'b0, mem_raddr_i} < RAM_LIMIT);
  assign wr_ram     = mem_wr_i && ({1'b0, mem_waddr_i} < RAM_LIMIT);
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);

  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_empty ? 16'h0000 : fifo_mem_q[rptr_q];

  assign push    = mem_wr_i && (mem_waddr_i == ADDR_TX);
  assign pop     = tx_valid_o && tx_ready_i;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
  assign push_ok = push && (!fifo_full || pop);

  always_comb begin
    rd_sel = 16'h0000;
    if (rd_ram) begin
      if (mem_wr_i && (mem_waddr_i == mem_raddr_i)) begin
        rd_sel = mem_wdata_i;
      end else begin
        rd_sel = ram_q[mem_raddr_i[RAM_AWIDTH-1:0]];
      end
    end else begin
      case (mem_raddr_i)
        ADDR_GPIO:   rd_sel = (mem_wr_i && (mem_waddr_i == ADDR_GPIO)) ? mem_wdata_i : gpio_q;
        ADDR_TX:     rd_sel = {{(16-CW){1'b0}}, count_q};
        ADDR_STATUS: rd_sel = {13'b0, ovf_q, fifo_empty, fifo_full};
        ADDR_CYCLE:  rd_sel = cycle_q;
        default:     rd_sel = 16'h0000;
      endcase
    end
  end

  always_comb begin
    mem_rdata_d = mem_rd_i ? rd_sel : mem_rdata_q;

    gpio_d = gpio_q;
    if (mem_wr_i && (mem_waddr_i == ADDR_GPIO)) begin
      gpio_d = mem_wdata_i;
    end

    cycle_d = cycle_q + 16'd1;
    if (mem_wr_i && (mem_waddr_i == ADDR_CYCLE)) begin
      cycle_d = 16'h0000;
    end

    ovf_d = ovf_q;
    if (mem_wr_i && (mem_waddr_i == ADDR_STATUS)) begin
      ovf_d = 1'b0;
    end
    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_rdata_q <= 16'h0000;
      gpio_q      <= 16'h0000;
      cycle_q     <= 16'h0000;
      ovf_q       <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      mem_rdata_q <= mem_rdata_d;
      gpio_q      <= gpio_d;
      cycle_q     <= cycle_d;
      ovf_q       <= ovf_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end

  // Storage arrays carry no reset; RAM contents must survive a reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ram) begin
      ram_q[mem_waddr_i[RAM_AWIDTH-1:0]] <= mem_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      fifo_mem_q[wptr_q] <= mem_wdata_i;
    end
  end

  assign mem_rdata_o = mem_rdata_q;
  assign gpio_o      = gpio_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: RAM, GPIO, TX FIFO, status, cycle counter and reset.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_raddr_i;
  logic        mem_rd_i;
  logic [15:0] mem_rdata_o;
  logic [15:0] mem_waddr_i;
  logic [15:0] mem_wdata_i;
  logic        mem_wr_i;
  logic [15:0] tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [15:0] gpio_o;

  int checks = 0;
  int errors = 0;

  cpu_mem_responder #(.RAM_AWIDTH(12), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_raddr_i (mem_raddr_i),
    .mem_rd_i    (mem_rd_i),
    .mem_rdata_o (mem_rdata_o),
    .mem_waddr_i (mem_waddr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_wr_i    (mem_wr_i),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .gpio_o      (gpio_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    mem_waddr_i = a;
    mem_wdata_i = d;
    mem_wr_i    = 1'b1;
    tick();
    mem_wr_i    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    mem_raddr_i = a;
    mem_rd_i    = 1'b1;
    tick();
    mem_rd_i    = 1'b0;
  endtask

  task automatic rw(input logic [15:0] ra, input logic [15:0] wa, input logic [15:0] d);
    mem_raddr_i = ra;
    mem_rd_i    = 1'b1;
    mem_waddr_i = wa;
    mem_wdata_i = d;
    mem_wr_i    = 1'b1;
    tick();
    mem_rd_i    = 1'b0;
    mem_wr_i    = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_raddr_i = '0;
    mem_rd_i    = 1'b0;
    mem_waddr_i = '0;
    mem_wdata_i = '0;
    mem_wr_i    = 1'b0;
    tx_ready_i  = 1'b0;
    tick();
    tick();
    chk("rst_rdata", mem_rdata_o, 16'h0000);
    chk("rst_gpio", gpio_o, 16'h0000);
    chk("rst_valid", {15'b0, tx_valid_o}, 16'h0000);
    chk("rst_txdata", tx_data_o, 16'h0000);
    rst_n = 1'b1;

    // RAM write, read, hold and write-first collision
    wr(16'h0010, 16'h1234);
    rd(16'h0010);
    chk("ram_rd", mem_rdata_o, 16'h1234);
    tick();
    chk("ram_hold", mem_rdata_o, 16'h1234);
    rw(16'h0010, 16'h0010, 16'hBEEF);
    chk("ram_wfirst", mem_rdata_o, 16'hBEEF);

    // TX push/pop ordering; count collision returns pre-edge value
    rw(16'hFF01, 16'hFF01, 16'h0041);
    chk("tx_cnt_coll", mem_rdata_o, 16'h0000);
    wr(16'hFF01, 16'h0042);
    wr(16'hFF01, 16'h0043);
    rd(16'hFF01);
    chk("tx_cnt3", mem_rdata_o, 16'h0003);
    chk("tx_valid3", {15'b0, tx_valid_o}, 16'h0001);
    chk("tx_head", tx_data_o, 16'h0041);
    tx_ready_i = 1'b1;
    chk("tx_pop0", tx_data_o, 16'h0041);
    tick();
    chk("tx_pop1", tx_data_o, 16'h0042);
    tick();
    chk("tx_pop2", tx_data_o, 16'h0043);
    tick();
    tx_ready_i = 1'b0;
    chk("tx_empty_valid", {15'b0, tx_valid_o}, 16'h0000);
    chk("tx_empty_data", tx_data_o, 16'h0000);

    // Full, overflow, push-with-pop on full, overflow clear
    for (int i = 0; i < 8; i++) wr(16'hFF01, 16'h0100 + 16'(i));
    rd(16'hFF02);
    chk("st_full", mem_rdata_o, 16'h0001);
    wr(16'hFF01, 16'h01EE);
    rd(16'hFF02);
    chk("st_ovf", mem_rdata_o, 16'h0005);
    rd(16'hFF01);
    chk("ovf_cnt", mem_rdata_o, 16'h0008);
    chk("ovf_head", tx_data_o, 16'h0100);
    rw(16'hFF02, 16'hFF02, 16'h0000);
    chk("st_coll", mem_rdata_o, 16'h0005);
    rd(16'hFF02);
    chk("st_clr", mem_rdata_o, 16'h0001);
    tx_ready_i = 1'b1;
    wr(16'hFF01, 16'h01FF);
    tx_ready_i = 1'b0;
    rd(16'hFF01);
    chk("pp_cnt", mem_rdata_o, 16'h0008);
    chk("pp_head", tx_data_o, 16'h0101);
    rd(16'hFF02);
    chk("pp_st", mem_rdata_o, 16'h0001);
    tx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain", tx_data_o, (i < 7) ? 16'h0101 + 16'(i) : 16'h01FF);
      tick();
    end
    tx_ready_i = 1'b0;
    chk("drain_valid", {15'b0, tx_valid_o}, 16'h0000);
    rd(16'hFF02);
    chk("st_empty", mem_rdata_o, 16'h0002);

    // Cycle counter: clear, count, wrap, collision
    wr(16'hFF03, 16'h0000);
    repeat (5) tick();
    rd(16'hFF03);
    chk("cyc5", mem_rdata_o, 16'h0005);
    wr(16'hFF03, 16'h0000);
    repeat (65536) tick();
    rd(16'hFF03);
    chk("cyc_wrap", mem_rdata_o, 16'h0000);
    rd(16'hFF03);
    chk("cyc_wrap1", mem_rdata_o, 16'h0001);
    rw(16'hFF03, 16'hFF03, 16'h0000);
    chk("cyc_coll", mem_rdata_o, 16'h0002);
    rd(16'hFF03);
    chk("cyc_clr", mem_rdata_o, 16'h0000);

    // GPIO and unmapped space
    wr(16'hFF00, 16'hA5A5);
    chk("gpio", gpio_o, 16'hA5A5);
    rd(16'hFF00);
    chk("gpio_rd", mem_rdata_o, 16'hA5A5);
    rw(16'hFF00, 16'hFF00, 16'h5A5A);
    chk("gpio_wfirst", mem_rdata_o, 16'h5A5A);
    wr(16'h0000, 16'h5555);
    wr(16'hF000, 16'h9999);
    rd(16'hF000);
    chk("unmap_f000", mem_rdata_o, 16'h0000);
    rd(16'h0000);
    chk("no_alias", mem_rdata_o, 16'h5555);
    rd(16'h1000);
    chk("unmap_1000", mem_rdata_o, 16'h0000);
    rd(16'hFF04);
    chk("unmap_ff04", mem_rdata_o, 16'h0000);

    // Mid-operation reset with a competing write
    wr(16'hFF00, 16'hFFFF);
    for (int i = 0; i < 5; i++) wr(16'hFF01, 16'h0200 + 16'(i));
    rd(16'h0010);
    chk("pre_rst_rd", mem_rdata_o, 16'hBEEF);
    rst_n = 1'b0;
    wr(16'hFF00, 16'h1111);
    rst_n = 1'b1;
    chk("mrst_rdata", mem_rdata_o, 16'h0000);
    chk("mrst_gpio", gpio_o, 16'h0000);
    chk("mrst_valid", {15'b0, tx_valid_o}, 16'h0000);
    chk("mrst_txdata", tx_data_o, 16'h0000);
    rd(16'hFF03);
    chk("mrst_cyc", mem_rdata_o, 16'h0000);
    rd(16'hFF01);
    chk("mrst_cnt", mem_rdata_o, 16'h0000);
    rd(16'hFF02);
    chk("mrst_st", mem_rdata_o, 16'h0002);
    rd(16'h0010);
    chk("mrst_ram", mem_rdata_o, 16'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
